// File: rtl/dcs_requant.sv
// Output requantizer: ping-pong buffers frames of N_WORDS words and emits each frame
// scaled by a per-frame power-of-two shift. Define DCSQ_ROUND_EN for round-half-up scaling.
module dcs_requant #(
    parameter int N_WORDS = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic [4:0]                 out_shift,
    output logic [$clog2(N_WORDS)-1:0] out_argmax,
    output logic                       ovf
);
    localparam int AW = $clog2(N_WORDS);
    localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);

    logic [N_WORDS-1:0][IN_W-1:0] mem [2];
    logic [IN_W-1:0] maxv [2];
    logic [AW-1:0]   amax [2];
    logic [4:0]      shft [2];
    logic [1:0]      full, sok;
    logic            wb, rb, drop;
    logic [AW-1:0]   wcnt, rcnt;

    logic hs, free, start, blocked, wr, last_in;

    function automatic logic [4:0] calc_shift(input logic [IN_W-1:0] m);
        logic [4:0] s;
        s = '0;
        for (int i = OUT_W; i < IN_W; i++)
            if (m[i]) s = 5'(i - (OUT_W - 1));
        return s;
    endfunction

    assign hs      = out_valid && out_ready;
    assign free    = hs && (rcnt == LAST);
    assign start   = in_valid && (wcnt == '0);
    // a buffer being drained on this very edge is already free for a new frame
    assign blocked = full[wb] && !(free && (rb == wb));
    assign wr      = in_valid && (start ? !blocked : !drop);
    assign last_in = in_valid && (wcnt == LAST);

    always_ff @(posedge clk) begin
        if (wr) mem[wb][wcnt] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                maxv[b] <= '0;
                amax[b] <= '0;
                shft[b] <= '0;
            end
            full <= '0;
            sok  <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
            drop <= 1'b0;
            wcnt <= '0;
            rcnt <= '0;
            ovf  <= 1'b0;
        end else begin
            // shift is derived one cycle after the frame lands, from its final max
            for (int b = 0; b < 2; b++) begin
                if (full[b] && !sok[b]) begin
                    sok[b]  <= 1'b1;
                    shft[b] <= calc_shift(maxv[b]);
                end
            end
            if (in_valid) begin
                wcnt <= last_in ? '0 : wcnt + 1'b1;
                if (start && blocked) begin
                    drop <= 1'b1;
                    ovf  <= 1'b1;
                end
                if (wr) begin
                    if (start || in_data > maxv[wb]) begin
                        maxv[wb] <= in_data;
                        amax[wb] <= wcnt;
                    end
                    if (last_in) begin
                        full[wb] <= 1'b1;
                        wb       <= ~wb;
                    end
                end
                if (last_in) drop <= 1'b0;
            end
            if (free) begin
                full[rb] <= 1'b0;
                sok[rb]  <= 1'b0;
                rb       <= ~rb;
                rcnt     <= '0;
            end else if (hs) begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    logic [IN_W:0] word, rnd, scaled;
    logic [4:0]    s_cur;

    always_comb begin
        s_cur = shft[rb];
        word  = {1'b0, mem[rb][rcnt]};
`ifdef DCSQ_ROUND_EN
        rnd   = (s_cur == 5'd0) ? '0 : ((IN_W+1)'(1) << (s_cur - 5'd1));
`else
        rnd   = '0;
`endif
        scaled = (word + rnd) >> s_cur;
    end

    assign out_valid  = full[rb] && sok[rb];
    assign out_data   = !out_valid ? '0 :
                        (|scaled[IN_W:OUT_W]) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    assign out_last   = out_valid && (rcnt == LAST);
    assign out_shift  = out_valid ? s_cur : 5'd0;
    assign out_argmax = out_valid ? amax[rb] : '0;
endmodule
